// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU: one operation in flight, registered ALU inputs, per-port response channels.
// Optional build macro ALU_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority (requester 0 wins ties).
module alu_arbiter (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [31:0] i_req0_operandA,
  input  logic [31:0] i_req0_operandB,
  input  logic [3:0]  i_req0_aluOp,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [31:0] i_req1_operandA,
  input  logic [31:0] i_req1_operandB,
  input  logic [3:0]  i_req1_aluOp,
  output logic        o_rsp0_valid,
  input  logic        i_rsp0_ready,
  output logic [31:0] o_rsp0_data,
  output logic        o_rsp1_valid,
  input  logic        i_rsp1_ready,
  output logic [31:0] o_rsp1_data,
  output logic [31:0] o_aluOperandA,
  output logic [31:0] o_aluOperandB,
  output logic [3:0]  o_aluOp,
  input  logic [31:0] i_aluData
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        owner;
  logic [31:0] result;
  logic        rsp_done;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant0 = i_req0_valid;
    grant1 = i_req1_valid & ~i_req0_valid;
  end
`else
  logic last_grant;

  // On a tie the requester not granted last wins; last_grant=1 lets requester 0 win first
  always_comb begin
    grant0 = i_req0_valid & (~i_req1_valid | last_grant);
    grant1 = i_req1_valid & (~i_req0_valid | ~last_grant);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= o_req1_ready;
  end
`endif

  assign o_req0_ready = (state == IDLE) & grant0;
  assign o_req1_ready = (state == IDLE) & grant1;
  assign accept       = o_req0_ready | o_req1_ready;

  assign o_rsp0_valid = (state == RESP) & ~owner;
  assign o_rsp1_valid = (state == RESP) & owner;
  assign o_rsp0_data  = result;
  assign o_rsp1_data  = result;
  assign rsp_done     = (o_rsp0_valid & i_rsp0_ready) | (o_rsp1_valid & i_rsp1_ready);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU input registers keep the last accepted operation until the next acceptance
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_aluOperandA <= '0;
      o_aluOperandB <= '0;
      o_aluOp       <= '0;
      owner         <= 1'b0;
    end else if (accept) begin
      o_aluOperandA <= o_req1_ready ? i_req1_operandA : i_req0_operandA;
      o_aluOperandB <= o_req1_ready ? i_req1_operandB : i_req0_operandB;
      o_aluOp       <= o_req1_ready ? i_req1_aluOp    : i_req0_aluOp;
      owner         <= o_req1_ready;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      result <= '0;
    else if (state == EXEC)
      result <= i_aluData;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: per-port expected-result queues and an expected grant-order queue.
// Grant expectations follow ALU_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        ready0, ready1;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_data;

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          last_accept = -1;
  bit          gap_check = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          grant_q[$];

  alu_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(req0_valid), .o_req0_ready(ready0),
    .i_req0_operandA(req0_a), .i_req0_operandB(req0_b), .i_req0_aluOp(req0_op),
    .i_req1_valid(req1_valid), .o_req1_ready(ready1),
    .i_req1_operandA(req1_a), .i_req1_operandB(req1_b), .i_req1_aluOp(req1_op),
    .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp0_ready), .o_rsp0_data(rsp0_data),
    .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp1_ready), .o_rsp1_data(rsp1_data),
    .o_aluOperandA(alu_a), .o_aluOperandB(alu_b), .o_aluOp(alu_op),
    .i_aluData(alu_data)
  );

  // ALU model: a plain adder
  assign alu_data = alu_a + alu_b;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cycle);
    end
  endtask

  // Response monitor: pops the owning port's queue on each response handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && rsp0_ready) begin
        if (exp_q0.size() == 0) checkOutput("rsp0_unexpected", 32'd1, 32'd0);
        else checkOutput("rsp0_data", rsp0_data, exp_q0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_q1.size() == 0) checkOutput("rsp1_unexpected", 32'd1, 32'd0);
        else checkOutput("rsp1_data", rsp1_data, exp_q1.pop_front());
      end
    end
  end

  // Acceptance monitor: grant order, exclusivity and acceptance spacing
  always @(negedge clk) begin
    if (rst_n && ((req0_valid && ready0) || (req1_valid && ready1))) begin
      checkOutput("ready_onehot", {31'd0, ready0 & ready1}, 32'd0);
      if (grant_q.size() > 0) checkOutput("grant_order", {31'd0, ready1}, grant_q.pop_front());
      if (gap_check && last_accept >= 0) checkOutput("accept_gap", cycle - last_accept, 32'd3);
      last_accept = cycle;
    end
  end

  task automatic applyStimulus(input int port, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit got = 0;
    if (port == 0) begin
      exp_q0.push_back(a + b);
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1;
    end else begin
      exp_q1.push_back(a + b);
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? ready0 : ready1;
    end
    if (!got) checkOutput("accept_timeout", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic applyReset();
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    checkOutput("reset_alu_a", alu_a, 32'd0);
    checkOutput("reset_alu_op", {28'd0, alu_op}, 32'd0);
    exp_q0.delete(); exp_q1.delete(); grant_q.delete();
    last_accept = -1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || rsp0_valid || rsp1_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", {31'd0, n >= 100}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;

    // Single request: acceptance timing, registered opcode, response latency
    applyReset();
    fork applyStimulus(0, 32'd5, 32'd7, 4'h3); join_none
    @(negedge clk);
    checkOutput("single_ready0", {31'd0, ready0}, 32'd1);
    @(negedge clk);
    checkOutput("single_alu_op", {28'd0, alu_op}, 32'h3);
    checkOutput("single_alu_a", alu_a, 32'd5);
    checkOutput("single_rsp0_early", {31'd0, rsp0_valid}, 32'd0);
    @(negedge clk);
    checkOutput("single_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("single_rsp0_data", rsp0_data, 32'd12);
    checkOutput("single_rsp1_quiet", {31'd0, rsp1_valid}, 32'd0);
    waitDrain();
    checkOutput("single_alu_op_hold", {28'd0, alu_op}, 32'h3);

    // Tie with both requesters continuously valid
    applyReset();
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_q.push_back(0); grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(1);
`else
    grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
`endif
    gap_check = 1;
    fork
      begin applyStimulus(0, 32'd1, 32'd1, 4'h0); applyStimulus(0, 32'd1, 32'd1, 4'h0); end
      begin applyStimulus(1, 32'd2, 32'd2, 4'h1); applyStimulus(1, 32'd2, 32'd2, 4'h1); end
    join
    waitDrain();
    gap_check = 0;
    checkOutput("tie_grants_consumed", grant_q.size(), 32'd0);

    // Response backpressure on port 1 with req0 waiting
    applyReset();
    rsp1_ready = 0;
    applyStimulus(1, 32'd10, 32'd20, 4'h1);
    fork applyStimulus(0, 32'd3, 32'd4, 4'h2); join_none
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_rsp1_rise", {31'd0, rsp1_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp1_hold", {31'd0, rsp1_valid}, 32'd1);
      checkOutput("bp_rsp1_data", rsp1_data, 32'd30);
      checkOutput("bp_req0_blocked", {31'd0, ready0}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp1_ready = 1;
    @(negedge clk);
    checkOutput("bp_req0_still_blocked", {31'd0, ready0}, 32'd0);
    @(negedge clk);
    checkOutput("bp_req0_after_hs", {31'd0, ready0}, 32'd1);
    waitDrain();

    // Asynchronous reset while in EXEC
    applyReset();
    req0_a = 32'd100; req0_b = 32'd1; req0_op = 4'h7; req0_valid = 1;
    @(negedge clk);
    checkOutput("mid_ready0", {31'd0, ready0}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 0;
    #1 rst_n = 0;
    #1;
    checkOutput("mid_rst_rsp0", {31'd0, rsp0_valid}, 32'd0);
    checkOutput("mid_rst_alu_a", alu_a, 32'd0);
    checkOutput("mid_rst_alu_b", alu_b, 32'd0);
    checkOutput("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
    @(negedge clk);
    checkOutput("mid_rst_held", {31'd0, rsp0_valid | rsp1_valid}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1;
    fork applyStimulus(0, 32'd40, 32'd2, 4'h5); join_none
    @(negedge clk);
    checkOutput("mid_ready0_after_reset", {31'd0, ready0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_rsp0_data", rsp0_data, 32'd42);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
